// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end that shares one rotation-mode CORDIC core between NREQ requesters.
// Only one operation is in flight at a time; the core's fixed latency is timed with a down-counter.
module cordic_rr_scheduler #(
  parameter int NREQ     = 4,
  parameter int W        = 16,
  parameter int CORE_LAT = 16,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_angle,
  input  logic [NREQ*W-1:0] req_xin,
  input  logic [NREQ*W-1:0] req_yin,
  output logic              core_start,
  output logic [W-1:0]      core_angle,
  output logic [W-1:0]      core_xin,
  output logic [W-1:0]      core_yin,
  input  logic [W-1:0]      core_xout,
  input  logic [W-1:0]      core_yout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_xout,
  output logic [W-1:0]      rsp_yout,
  output logic              busy
);

  localparam int CNTW = $clog2(CORE_LAT);
  localparam logic [NREQ-1:0] LSB_ONE = NREQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_last_grant;
  logic [IDW-1:0]  r_grant;
  logic [CNTW-1:0] r_cnt;
  logic            r_core_start;
  logic            r_rsp_valid;
  logic            r_busy;
  logic [W-1:0]    r_angle;
  logic [W-1:0]    r_xin;
  logic [W-1:0]    r_yin;
  logic [IDW-1:0]  r_rsp_id;
  logic [W-1:0]    r_rsp_xout;
  logic [W-1:0]    r_rsp_yout;
  logic            w_found;
  logic [IDW-1:0]  w_pick;
  logic [IDW-1:0]  w_cand;
  logic            w_accept;

  // Round-robin search: first valid requester after the last completed grant, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(r_last_grant) + k) % NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_accept = (r_state == ST_IDLE) && w_found;

  // Combinational one-hot accept, forced low while reset is held.
  always_comb begin
    if (reset && w_accept) begin
      req_ready = LSB_ONE << w_pick;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_state_nxt = ST_ISSUE;
        else         w_state_nxt = ST_IDLE;
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_RESP;
        else             w_state_nxt = ST_WAIT;
      end
      ST_RESP: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
        else           w_state_nxt = ST_RESP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, flags decoded one cycle early so the outputs come straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_core_start <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= '0;
      r_last_grant <= IDW'(NREQ - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_core_start <= (w_state_nxt == ST_ISSUE);
      r_rsp_valid  <= (w_state_nxt == ST_RESP);
      r_busy       <= (w_state_nxt != ST_IDLE);
      if (r_state == ST_ISSUE) begin
        r_cnt <= CNTW'(CORE_LAT - 1);
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNTW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
      if ((r_state == ST_RESP) && rsp_ready) begin
        r_last_grant <= r_grant;
      end else begin
        r_last_grant <= r_last_grant;
      end
    end
  end

  // Operand/grant latch on accept and result capture on the core's valid cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant    <= '0;
      r_angle    <= '0;
      r_xin      <= '0;
      r_yin      <= '0;
      r_rsp_id   <= '0;
      r_rsp_xout <= '0;
      r_rsp_yout <= '0;
    end else begin
      if (w_accept) begin
        r_grant <= w_pick;
        r_angle <= req_angle[int'(w_pick)*W +: W];
        r_xin   <= req_xin[int'(w_pick)*W +: W];
        r_yin   <= req_yin[int'(w_pick)*W +: W];
      end
      if ((r_state == ST_WAIT) && (r_cnt == '0)) begin
        r_rsp_id   <= r_grant;
        r_rsp_xout <= core_xout;
        r_rsp_yout <= core_yout;
      end
    end
  end

  assign core_start = r_core_start;
  assign core_angle = r_angle;
  assign core_xin   = r_xin;
  assign core_yin   = r_yin;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_xout   = r_rsp_xout;
  assign rsp_yout   = r_rsp_yout;
  assign busy       = r_busy;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler: table of {request mask, expected grant, backpressure} records
// with a behavioural fixed-latency core and a response scoreboard queue.
module tb_cordic_rr_scheduler;
  localparam int NREQ = 4;
  localparam int W = 16;
  localparam int CORE_LAT = 16;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_angle = '0;
  logic [NREQ*W-1:0] req_xin = '0;
  logic [NREQ*W-1:0] req_yin = '0;
  logic              core_start;
  logic [W-1:0]      core_angle, core_xin, core_yin;
  logic [W-1:0]      core_xout, core_yout;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_xout, rsp_yout;
  logic              busy;

  cordic_rr_scheduler #(.NREQ(NREQ), .W(W), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_angle(req_angle), .req_xin(req_xin), .req_yin(req_yin),
    .core_start(core_start), .core_angle(core_angle), .core_xin(core_xin), .core_yin(core_yin),
    .core_xout(core_xout), .core_yout(core_yout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_xout(rsp_xout), .rsp_yout(rsp_yout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model: result valid only in the cycle CORE_LAT after the start cycle, junk otherwise.
  logic [W-1:0] m_ang = '0, m_x = '0, m_y = '0;
  int           m_cnt = 0;
  logic         m_act = 1'b0;
  always @(posedge clk) begin
    if (core_start) begin
      m_ang <= core_angle;
      m_x   <= core_xin;
      m_y   <= core_yin;
      m_cnt <= CORE_LAT - 1;
      m_act <= 1'b1;
    end else if (m_act) begin
      if (m_cnt == 0) m_act <= 1'b0;
      else            m_cnt <= m_cnt - 1;
    end
  end
  assign core_xout = (m_act && m_cnt == 0) ? (m_x ^ m_ang) : 16'hDEAD;
  assign core_yout = (m_act && m_cnt == 0) ? (m_y + m_ang) : 16'hBEEF;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] op_ang [NREQ];
  logic [W-1:0] op_x   [NREQ];
  logic [W-1:0] op_y   [NREQ];

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
  } rsp_t;
  rsp_t sb[$];

  typedef struct {
    int              pre;    // 0 none, 1 reset, 2 abort sequence
    logic [NREQ-1:0] mask;
    int              exp_id;
    int              hold;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic do_abort();
    int seen;
    req_valid = 4'b0001;
    #1;
    step();
    repeat (11) step();
    chk("abort_busy_before", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_ctrl_zero", {req_ready, core_start, rsp_valid, rsp_id, busy}, 64'd0);
    chk("abort_core_zero", {core_angle, core_xin, core_yin}, 64'd0);
    chk("abort_rsp_zero", {rsp_xout, rsp_yout}, 64'd0);
    req_valid = '0;
    step();
    step();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (rsp_valid || core_start) seen++;
    end
    chk("abort_no_rsp", seen, 0);
  endtask

  task automatic run_op(input logic [NREQ-1:0] mask, input int exp_id, input int hold);
    rsp_t e;
    rsp_t got;
    int n, lat, starts;
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[exp_id] = 1'b1;
    rsp_ready = (hold == 0);
    req_valid = mask;
    #1;
    n = 0;
    while (req_ready == '0 && n < 40) begin
      step();
      n++;
    end
    chk("grant_onehot", req_ready, oh);
    e.id = IDW'(exp_id);
    e.x  = op_x[exp_id] ^ op_ang[exp_id];
    e.y  = op_y[exp_id] + op_ang[exp_id];
    sb.push_back(e);
    step();
    chk("core_start_pulse", core_start, 1'b1);
    chk("core_operands", {core_angle, core_xin, core_yin}, {op_ang[exp_id], op_x[exp_id], op_y[exp_id]});
    chk("ready_low_after_accept", req_ready, 4'b0000);
    chk("busy_issue", busy, 1'b1);
    lat = 1;
    starts = 0;
    while (!rsp_valid && lat < CORE_LAT + 20) begin
      step();
      lat++;
      if (core_start) starts++;
    end
    chk("rsp_latency", lat, CORE_LAT + 2);
    chk("single_start", starts, 0);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      got = e;
    end else begin
      got = sb.pop_front();
    end
    for (int h = 0; h < hold; h++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_stable", {rsp_id, rsp_xout, rsp_yout}, {got.id, got.x, got.y});
      chk("bp_ready_low", req_ready, 4'b0000);
      chk("bp_no_start", core_start, 1'b0);
      chk("bp_operands_held", {core_angle, core_xin, core_yin}, {op_ang[exp_id], op_x[exp_id], op_y[exp_id]});
      step();
    end
    rsp_ready = 1'b1;
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_id", rsp_id, got.id);
    chk("rsp_xout", rsp_xout, got.x);
    chk("rsp_yout", rsp_yout, got.y);
    step();
    chk("rsp_done", rsp_valid, 1'b0);
    chk("idle_not_busy", busy, 1'b0);
  endtask

  initial begin
    op_ang[0] = 16'd1000;  op_x[0] = 16'hFF38; op_y[0] = 16'd50;
    op_ang[1] = 16'd7500;  op_x[1] = 16'd400;  op_y[1] = 16'd300;
    op_ang[2] = 16'hFFFF;  op_x[2] = 16'h7FFF; op_y[2] = 16'h8000;
    op_ang[3] = 16'd12345; op_x[3] = 16'hFFFF; op_y[3] = 16'h0001;
    for (int i = 0; i < NREQ; i++) begin
      req_angle[i*W +: W] = op_ang[i];
      req_xin[i*W +: W]   = op_x[i];
      req_yin[i*W +: W]   = op_y[i];
    end

    tbl[0]  = '{pre: 1, mask: 4'b1111, exp_id: 0, hold: 0};
    tbl[1]  = '{pre: 0, mask: 4'b1111, exp_id: 1, hold: 0};
    tbl[2]  = '{pre: 0, mask: 4'b1111, exp_id: 2, hold: 0};
    tbl[3]  = '{pre: 0, mask: 4'b1111, exp_id: 3, hold: 0};
    tbl[4]  = '{pre: 0, mask: 4'b1111, exp_id: 0, hold: 0};
    tbl[5]  = '{pre: 0, mask: 4'b1111, exp_id: 1, hold: 0};
    tbl[6]  = '{pre: 0, mask: 4'b0010, exp_id: 1, hold: 0};
    tbl[7]  = '{pre: 0, mask: 4'b0100, exp_id: 2, hold: 10};
    tbl[8]  = '{pre: 0, mask: 4'b1001, exp_id: 3, hold: 0};
    tbl[9]  = '{pre: 0, mask: 4'b1001, exp_id: 0, hold: 0};
    tbl[10] = '{pre: 2, mask: 4'b1001, exp_id: 0, hold: 0};
    tbl[11] = '{pre: 0, mask: 4'b1001, exp_id: 3, hold: 0};
    tbl[12] = '{pre: 0, mask: 4'b0110, exp_id: 1, hold: 0};

    // Reset held with requests pending: everything must read zero.
    reset = 1'b0;
    req_valid = 4'b1111;
    #3;
    chk("reset_ctrl_zero", {req_ready, core_start, rsp_valid, rsp_id, busy}, 64'd0);
    step();
    chk("reset_core_zero", {core_angle, core_xin, core_yin}, 64'd0);
    chk("reset_rsp_zero", {rsp_xout, rsp_yout}, 64'd0);

    for (int t = 0; t < 13; t++) begin
      if (tbl[t].pre == 1) do_reset();
      else if (tbl[t].pre == 2) do_abort();
      run_op(tbl[t].mask, tbl[t].exp_id, tbl[t].hold);
    end
    req_valid = '0;
    step();
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
